e203_exu_oitf_trk: RTL and testbench
====================================

Name: e203_exu_oitf_trk

Overview:
Outstanding Instruction Track FIFO for long-pipe instructions, such as LSU loads and stores.
- Dispatch allocates one entry per long-pipe instruction and receives an ITAG.
- The long-pipe write-back arbiter retires entries strictly in order, using the read pointer, rd index, pc and rdwen exported here.
- Dispatch also uses the block's RAW/WAW hazard flags against the instruction it is issuing.

Parameters:
DEPTH, 2, number of entries; power of two, range 2..16.
ITAG_W, clog2(DEPTH), ITAG width; derived, equals `E203_ITAG_WIDTH in the core configuration.
RFIDX_W, 5, register-file index width (`E203_RFIDX_WIDTH).
PC_W, 32, pc width (`E203_PC_SIZE).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
dis_ena  in  1  allocate request from dispatch
dis_ready  out  1  allocation possible (= ~full)
dis_ptr  out  ITAG_W  ITAG given to the instruction allocated this cycle (= write pointer)
dis_rdidx  in  RFIDX_W  destination register of the allocating instruction
dis_rdwen  in  1  allocating instruction writes rd
dis_pc  in  PC_W  pc of the allocating instruction
dis_rs1en, dis_rs2en  in  1 each  source-operand valid flags for the hazard check
dis_rs1idx, dis_rs2idx  in  RFIDX_W each  source indexes for the hazard check
oitfrd_match_disrs1, oitfrd_match_disrs2, oitfrd_match_disrd  out  1 each  hazard flags
ret_ena  in  1  retire the oldest entry (driven by the write-back arbiter)
ret_ptr  out  ITAG_W  read pointer
ret_rdidx  out  RFIDX_W  rd index of the oldest entry
ret_rdwen  out  1  rdwen of the oldest entry
ret_pc  out  PC_W  pc of the oldest entry
oitf_empty  out  1  no valid entries
oitf_full  out  1  all entries valid

Behaviour:
Reset and clocking
- Single clock domain.
- rst is synchronous and active-high: it is sampled only on the clk rising edge.
- Reset values: wptr=0, rptr=0, both wrap flags=0, all entry valid bits=0.
- Resulting outputs after reset: oitf_empty=1, oitf_full=0, dis_ready=1, dis_ptr=0, ret_ptr=0, all match flags=0.
- Entry payload registers (rdidx/rdwen/pc) are not reset. When the FIFO is empty, ret_rdidx/ret_rdwen/ret_pc are don't-care.
- Reset asserted mid-operation discards all outstanding entries in the same edge.

Pointers and status
- wptr and rptr are each ITAG_W bits plus a wrap flag.
- Each pointer increments modulo DEPTH; its wrap flag toggles when the pointer passes DEPTH-1 back to 0.
- empty = (wptr==rptr) & (wrap flags equal).
- full = (wptr==rptr) & (wrap flags differ).
- All status outputs are registered-state derived, with no combinational path from dis_ena or ret_ena.

Allocate
- Allocation occurs when alloc = dis_ena & ~full.
- On alloc, at the clock edge: entry[wptr] is loaded with {rdidx, rdwen, pc}, valid[wptr] is set, and wptr advances.
- dis_ptr shows the ITAG before the advance.
- dis_ena while full is ignored, leaving state unchanged; a bench assertion flags this as a protocol error.

Retire
- Retirement occurs when retire = ret_ena & ~empty.
- On retire: valid[rptr] is cleared and rptr advances.
- ret_ena while empty is ignored; a bench assertion flags this.
- The ret_* outputs are a combinational read of entry[rptr], so data is available with zero latency.

Simultaneous events
- alloc and retire in the same cycle both take effect, and occupancy is unchanged.
- When full, dis_ready=0 even if ret_ena is high in that cycle; there is no same-cycle bypass.
- When empty, a same-cycle alloc does not make ret_* valid until the next cycle.

Hazard check (combinational over registered state)
- oitfrd_match_disrs1 = dis_rs1en & OR over i of (valid[i] & rdwen[i] & rdidx[i]==dis_rs1idx).
- oitfrd_match_disrs2 is computed the same way from dis_rs2en/dis_rs2idx.
- oitfrd_match_disrd = dis_rdwen & the same OR against dis_rdidx.
- x0 is not special-cased; dispatch masks it.
- An entry retiring in the current cycle still counts as valid, which is deliberately conservative.
- An entry allocating in the current cycle is not visible until the next cycle.

Latency and throughput
- One allocation and one retirement per cycle maximum.
- Retire data is visible in the cycle after allocation at the earliest.

Decomposition:
- Shared package/defines: ITAG width, RFIDX width and PC width, taken from the existing `E203_* defines.
- Shared package: an entry struct {rdidx, rdwen, pc}.
- Natural sub-module: e203_exu_oitf_ptr, a ptr+wrap-flag counter instantiated twice, for write and read.
- The storage array and hazard compare stay inline.

Test Plan:
1. Reset then idle -> oitf_empty=1, oitf_full=0, dis_ready=1, dis_ptr=0, ret_ptr=0, all match flags 0.
2. DEPTH=2: alloc rd=5 pc=0x100, then alloc rd=7 pc=0x104 -> dis_ptr 0 then 1, oitf_full=1, dis_ready=0. A third dis_ena is ignored, with ret_pc=0x100 and ret_rdidx=5 unchanged.
3. From full, retire twice -> ret_pc 0x100 then 0x104, ret_ptr 0 then 1, then oitf_empty=1. Pointer wraps so the next dis_ptr=0.
4. One entry valid (rd=9, rdwen=1); drive alloc and retire in the same cycle -> occupancy stays 1, ret_ptr advances by 1, new entry becomes the head next cycle.
5. Entry rd=3 with rdwen=1, and entry rd=4 with rdwen=0:
   - dis_rs1idx=3, rs1en=1 -> match_disrs1=1.
   - dis_rs2idx=4, rs2en=1 -> match_disrs2=0 (that entry does not write rd).
   - dis_rdidx=3, rdwen=1 -> match_disrd=1.
   - The same query with rs1en=0 -> match_disrs1=0.
6. Assert rst with 2 entries valid mid-stream -> next cycle oitf_empty=1 and all pointers 0. A stale ret_ena in that cycle is ignored.

Source files
------------

// File: rtl/e203_exu_oitf_trk_pkg.sv
// Shared widths and entry layout for the outstanding instruction track FIFO.
// Widths follow the core configuration values.
package e203_exu_oitf_trk_pkg;

  localparam int RFIDX_W = 5;

  localparam int PC_W = 32;

  // ITAG width for a given depth; a depth of 1 still needs one tag bit.
  function automatic int itag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One tracked long-pipe instruction.
  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic               rdwen;
    logic [PC_W-1:0]    pc;
  } oitf_entry_t;

endpackage

// File: rtl/e203_exu_oitf_trk_if.sv
// Dispatch / write-back side bundle of the OITF.
// The slave modport is the FIFO itself; master is dispatch plus the retire arbiter.
interface e203_exu_oitf_trk_if
  import e203_exu_oitf_trk_pkg::*;
#(
  parameter int DEPTH = 2
);
  localparam int ITAG_W = itag_width(DEPTH);

  logic               dis_ena;
  logic               dis_ready;
  logic [ITAG_W-1:0]  dis_ptr;
  logic [RFIDX_W-1:0] dis_rdidx;
  logic               dis_rdwen;
  logic [PC_W-1:0]    dis_pc;
  logic               dis_rs1en;
  logic               dis_rs2en;
  logic [RFIDX_W-1:0] dis_rs1idx;
  logic [RFIDX_W-1:0] dis_rs2idx;
  logic               oitfrd_match_disrs1;
  logic               oitfrd_match_disrs2;
  logic               oitfrd_match_disrd;
  logic               ret_ena;
  logic [ITAG_W-1:0]  ret_ptr;
  logic [RFIDX_W-1:0] ret_rdidx;
  logic               ret_rdwen;
  logic [PC_W-1:0]    ret_pc;
  logic               oitf_empty;
  logic               oitf_full;

  modport master (
    output dis_ena, dis_rdidx, dis_rdwen, dis_pc,
    output dis_rs1en, dis_rs2en, dis_rs1idx, dis_rs2idx,
    output ret_ena,
    input  dis_ready, dis_ptr,
    input  oitfrd_match_disrs1, oitfrd_match_disrs2, oitfrd_match_disrd,
    input  ret_ptr, ret_rdidx, ret_rdwen, ret_pc,
    input  oitf_empty, oitf_full
  );

  modport slave (
    input  dis_ena, dis_rdidx, dis_rdwen, dis_pc,
    input  dis_rs1en, dis_rs2en, dis_rs1idx, dis_rs2idx,
    input  ret_ena,
    output dis_ready, dis_ptr,
    output oitfrd_match_disrs1, oitfrd_match_disrs2, oitfrd_match_disrd,
    output ret_ptr, ret_rdidx, ret_rdwen, ret_pc,
    output oitf_empty, oitf_full
  );

endinterface

// File: rtl/e203_exu_oitf_ptr.sv
// Pointer with wrap flag; the flag distinguishes full from empty when the
// write and read pointers coincide.
module e203_exu_oitf_ptr #(
  parameter int DEPTH  = 2,
  parameter int ITAG_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ITAG_W-1:0] ptr,
  output logic              flag
);

  logic [ITAG_W-1:0] ptr_r;
  logic              flag_r;

  // Advance modulo DEPTH, toggling the wrap flag on the DEPTH-1 -> 0 step.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r  <= '0;
      flag_r <= 1'b0;
    end else if (inc) begin
      if (ptr_r == ITAG_W'(DEPTH - 1)) begin
        ptr_r  <= '0;
        flag_r <= ~flag_r;
      end else begin
        ptr_r  <= ptr_r + ITAG_W'(1);
      end
    end
  end

  assign ptr  = ptr_r;
  assign flag = flag_r;

endmodule

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding Instruction Track FIFO: tracks long-pipe instructions from
// dispatch until in-order write-back, and flags RAW/WAW hazards for dispatch.
module e203_exu_oitf_trk
  import e203_exu_oitf_trk_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  e203_exu_oitf_trk_if.slave    bus
);

  localparam int ITAG_W = itag_width(DEPTH);

  logic [ITAG_W-1:0] wptr_s;
  logic [ITAG_W-1:0] rptr_s;
  logic              wflag_s;
  logic              rflag_s;
  logic              empty_s;
  logic              full_s;
  logic              alloc_s;
  logic              retire_s;
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  valid_nxt_s;
  oitf_entry_t       entries_r [DEPTH];
  oitf_entry_t       new_entry_s;
  oitf_entry_t       head_s;
  logic              hit_rs1_s;
  logic              hit_rs2_s;
  logic              hit_rd_s;

  // Status comes from registered pointers only; no path from the enables.
  assign empty_s  = (wptr_s == rptr_s) & (wflag_s == rflag_s);
  assign full_s   = (wptr_s == rptr_s) & (wflag_s != rflag_s);
  assign alloc_s  = bus.dis_ena & ~full_s;
  assign retire_s = bus.ret_ena & ~empty_s;

  e203_exu_oitf_ptr #(.DEPTH(DEPTH), .ITAG_W(ITAG_W)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (alloc_s),
    .ptr  (wptr_s),
    .flag (wflag_s)
  );

  e203_exu_oitf_ptr #(.DEPTH(DEPTH), .ITAG_W(ITAG_W)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (retire_s),
    .ptr  (rptr_s),
    .flag (rflag_s)
  );

  assign new_entry_s.rdidx = bus.dis_rdidx;
  assign new_entry_s.rdwen = bus.dis_rdwen;
  assign new_entry_s.pc    = bus.dis_pc;

  // Next valid vector: set the allocated slot, clear the retired slot.
  // Both cannot target the same slot since that needs full and empty at once.
  always_comb begin
    valid_nxt_s = valid_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_s && (wptr_s == ITAG_W'(i))) begin
        valid_nxt_s[i] = 1'b1;
      end else if (retire_s && (rptr_s == ITAG_W'(i))) begin
        valid_nxt_s[i] = 1'b0;
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end
  end

  // Valid bits are the only per-entry state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      valid_r <= valid_nxt_s;
    end
  end

  // Payload storage; contents are meaningless while the slot is invalid.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      entries_r[wptr_s] <= new_entry_s;
    end
  end

  // Hazard compare against every live entry that writes rd. An entry retiring
  // this cycle still matches, which is safe; a same-cycle allocation does not.
  always_comb begin
    hit_rs1_s = 1'b0;
    hit_rs2_s = 1'b0;
    hit_rd_s  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_rs1_s = hit_rs1_s | (valid_r[i] & entries_r[i].rdwen & (entries_r[i].rdidx == bus.dis_rs1idx));
      hit_rs2_s = hit_rs2_s | (valid_r[i] & entries_r[i].rdwen & (entries_r[i].rdidx == bus.dis_rs2idx));
      hit_rd_s  = hit_rd_s  | (valid_r[i] & entries_r[i].rdwen & (entries_r[i].rdidx == bus.dis_rdidx));
    end
  end

  assign head_s = entries_r[rptr_s];

  assign bus.dis_ready           = ~full_s;
  assign bus.dis_ptr             = wptr_s;
  assign bus.ret_ptr             = rptr_s;
  assign bus.ret_rdidx           = head_s.rdidx;
  assign bus.ret_rdwen           = head_s.rdwen;
  assign bus.ret_pc              = head_s.pc;
  assign bus.oitf_empty          = empty_s;
  assign bus.oitf_full           = full_s;
  assign bus.oitfrd_match_disrs1 = bus.dis_rs1en & hit_rs1_s;
  assign bus.oitfrd_match_disrs2 = bus.dis_rs2en & hit_rs2_s;
  assign bus.oitfrd_match_disrd  = bus.dis_rdwen & hit_rd_s;

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Self-checking bench for e203_exu_oitf_trk: directed scenarios followed by
// random traffic, all compared against a queue-based model of the FIFO.
module tb_e203_exu_oitf_trk;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
  } ment_t;

  logic clk;
  logic rst;

  e203_exu_oitf_trk_if #(.DEPTH(DEPTH)) bus ();

  e203_exu_oitf_trk #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ment_t       q[$];
  int unsigned alloc_n;
  int unsigned ret_n;
  int          n_vec;
  int          n_err;
  int          n_proto;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does any tracked rd-writing instruction target this register?
  function automatic logic model_hit(input logic [4:0] idx);
    foreach (q[i]) begin
      if (q[i].we && q[i].rd == idx) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model with the edge.
  task automatic step();
    bit al;
    bit rt;
    @(negedge clk);
    check_val("empty",     bus.oitf_empty, q.size() == 0);
    check_val("full",      bus.oitf_full,  q.size() == DEPTH);
    check_val("dis_ready", bus.dis_ready,  q.size() < DEPTH);
    check_val("dis_ptr",   bus.dis_ptr,    alloc_n % DEPTH);
    check_val("ret_ptr",   bus.ret_ptr,    ret_n % DEPTH);
    check_val("m_rs1", bus.oitfrd_match_disrs1, bus.dis_rs1en & model_hit(bus.dis_rs1idx));
    check_val("m_rs2", bus.oitfrd_match_disrs2, bus.dis_rs2en & model_hit(bus.dis_rs2idx));
    check_val("m_rd",  bus.oitfrd_match_disrd,  bus.dis_rdwen & model_hit(bus.dis_rdidx));
    if (q.size() > 0) begin
      check_val("ret_rdidx", bus.ret_rdidx, q[0].rd);
      check_val("ret_rdwen", bus.ret_rdwen, q[0].we);
      check_val("ret_pc",    bus.ret_pc,    q[0].pc);
    end
    al = bus.dis_ena && (q.size() < DEPTH);
    rt = bus.ret_ena && (q.size() > 0);
    if (rst) begin
      q.delete();
      alloc_n = 0;
      ret_n   = 0;
    end else begin
      if (bus.dis_ena && q.size() == DEPTH) begin
        n_proto++;
        $display("note: protocol violation, dis_ena while full at %0t", $time);
      end
      if (bus.ret_ena && q.size() == 0) begin
        n_proto++;
        $display("note: protocol violation, ret_ena while empty at %0t", $time);
      end
      if (rt) begin
        void'(q.pop_front());
        ret_n++;
      end
      if (al) begin
        q.push_back('{rd: bus.dis_rdidx, we: bus.dis_rdwen, pc: bus.dis_pc});
        alloc_n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dis_ena    = 1'b0;
    bus.dis_rdidx  = 5'd0;
    bus.dis_rdwen  = 1'b0;
    bus.dis_pc     = 32'h0;
    bus.dis_rs1en  = 1'b0;
    bus.dis_rs2en  = 1'b0;
    bus.dis_rs1idx = 5'd0;
    bus.dis_rs2idx = 5'd0;
    bus.ret_ena    = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic we, input logic [31:0] pc);
    idle_inputs();
    bus.dis_ena   = 1'b1;
    bus.dis_rdidx = rd;
    bus.dis_rdwen = we;
    bus.dis_pc    = pc;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_proto = 0;
    alloc_n = 0; ret_n = 0;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle.
    step();
    step();

    // Fill to full, then a third dis_ena that must be ignored.
    alloc(5'd5, 1'b1, 32'h100); step();
    alloc(5'd7, 1'b1, 32'h104); step();
    alloc(5'd9, 1'b1, 32'h108); step();
    idle_inputs(); step();
    check_val("p2_ret_pc", bus.ret_pc, 32'h100);
    check_val("p2_ret_rd", bus.ret_rdidx, 5'd5);

    // Drain twice; pointers wrap.
    idle_inputs(); bus.ret_ena = 1'b1; step();
    idle_inputs(); bus.ret_ena = 1'b1; step();
    idle_inputs(); step();
    check_val("p3_dis_ptr", bus.dis_ptr, 1'b0);

    // One entry, then simultaneous alloc and retire.
    alloc(5'd9, 1'b1, 32'h200); step();
    alloc(5'd10, 1'b1, 32'h204); bus.ret_ena = 1'b1; step();
    idle_inputs(); step();
    idle_inputs(); bus.ret_ena = 1'b1; step();

    // Hazard queries against rd=3 (writes) and rd=4 (no write).
    alloc(5'd3, 1'b1, 32'h300); step();
    alloc(5'd4, 1'b0, 32'h304); step();
    idle_inputs();
    bus.dis_rs1en = 1'b1; bus.dis_rs1idx = 5'd3;
    bus.dis_rs2en = 1'b1; bus.dis_rs2idx = 5'd4;
    bus.dis_rdwen = 1'b1; bus.dis_rdidx  = 5'd3;
    step();
    bus.dis_rs1en = 1'b0;
    step();

    // Reset with two entries outstanding and a stale ret_ena.
    idle_inputs(); rst = 1'b1; bus.ret_ena = 1'b1; step();
    rst = 1'b0; step();
    idle_inputs(); step();

    // Random traffic, hazard queries and occasional resets.
    for (int n = 0; n < 400; n++) begin
      bus.dis_ena    = ($urandom_range(0, 99) < 60);
      bus.dis_rdidx  = 5'($urandom_range(0, 7));
      bus.dis_rdwen  = 1'($urandom_range(0, 1));
      bus.dis_pc     = $urandom;
      bus.dis_rs1en  = 1'($urandom_range(0, 1));
      bus.dis_rs2en  = 1'($urandom_range(0, 1));
      bus.dis_rs1idx = 5'($urandom_range(0, 7));
      bus.dis_rs2idx = 5'($urandom_range(0, 7));
      bus.ret_ena    = ($urandom_range(0, 99) < 50);
      rst            = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("protocol notes: %0d", n_proto);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
